// File: rtl/mem_access_unit.sv
// Memory-access stage of the RV32I pipeline: drives the data-memory bus for loads and stores,
// aligns/extends load data, and stalls upstream while a bus transaction is outstanding.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic              MemRd_i,
    input  logic              MemWr_i,
    input  logic [2:0]        Funct3_i,
    input  logic [ADDR_W-1:0] ALUOut_i,
    input  logic [DATA_W-1:0] DataB_i,
    input  logic              RegWEn_i,
    input  logic [4:0]        AddrD_i,
    output logic              RegWEn_o,
    output logic [4:0]        AddrD_o,
    output logic [DATA_W-1:0] DataD_o,
    output logic              stall_o,
    output logic              fault_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic       mem_op;
    logic       f3_legal;
    logic       misalign;
    logic       fault;
    logic       go;
    logic [1:0] off;

    assign off    = ALUOut_i[1:0];
    assign mem_op = valid_i & (MemRd_i | MemWr_i);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        f3_legal = 1'b0;
        case (Funct3_i)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = MemRd_i;
            default:                f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (Funct3_i[1:0])
            2'b01:   misalign = off[0];
            2'b10:   misalign = |off;
            default: misalign = 1'b0;
        endcase
    end

    assign fault = mem_op & (~f3_legal | misalign);
    assign go    = mem_op & ~fault;

    // Store lane steering; loads always read the full word and extract locally.
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        be    = 4'b1111;
        wdata = DataB_i;
        if (MemWr_i) begin
            case (Funct3_i[1:0])
                2'b00: begin
                    be    = 4'b0001 << off;
                    wdata = {4{DataB_i[7:0]}};
                end
                2'b01: begin
                    be    = off[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{DataB_i[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = DataB_i;
                end
            endcase
        end
    end

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (off)
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            2'b11:   ld_byte = dmem_rdata_i[31:24];
            default: ld_byte = dmem_rdata_i[7:0];
        endcase
        ld_half = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (Funct3_i)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // A store granted in the cycle it is presented finishes without a stall;
    // a load always waits at least one cycle in RESP for its data.
    always_comb begin
        state_d    = state_q;
        dmem_req_o = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    dmem_req_o = 1'b1;
                    if (dmem_gnt_i) begin
                        stall_o = ~MemWr_i;
                        state_d = MemWr_i ? S_IDLE : S_RESP;
                    end else begin
                        stall_o = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                if (dmem_gnt_i) begin
                    stall_o = ~MemWr_i;
                    state_d = MemWr_i ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (dmem_rvalid_i) begin
                    state_d = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign fault_o      = fault;
    assign dmem_we_o    = MemWr_i;
    assign dmem_addr_o  = {ALUOut_i[ADDR_W-1:2], 2'b00};
    assign dmem_be_o    = be;
    assign dmem_wdata_o = wdata;

    assign AddrD_o  = AddrD_i;
    assign DataD_o  = (valid_i & MemRd_i) ? ld_data : DATA_W'(ALUOut_i);
    assign RegWEn_o = valid_i & RegWEn_i & ~MemWr_i & ~fault & ~stall_o;

endmodule
